// File: rtl/rb_seq_pkg.sv
// Shared types and constants for the register-bank transfer sequencer.
package rb_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_MOVE  = 2'd1,
        OP_SWAP  = 2'd2,
        OP_CLEAR = 2'd3
    } rb_seq_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR1  = 3'd2,
        ST_WR2  = 3'd3,
        ST_CLR  = 3'd4
    } rb_seq_state_t;

    localparam int         RB_SEL_W       = 4;
    localparam int         RB_NREGS       = 16;
    localparam logic [3:0] RB_HIDDEN_BASE = 4'h8;

endpackage

// File: rtl/rb_seq.sv
// Sequencer that runs LOAD/MOVE/SWAP/CLEAR as fixed multi-cycle transfers on the
// register bank's select/write port.
//
// state | meaning
// IDLE  | ready for a command; bank port idle
// RD    | source (and dest for SWAP) on read ports, captured into t0/t1
// WR1   | write dst with immediate (LOAD) or t0
// WR2   | SWAP only: write src with t1
// CLR   | write zero to register cnt, cnt 0..15
module rb_seq
    import rb_seq_pkg::*;
#(
    parameter int DW = 16,
    parameter int SW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  rb_seq_op_t      cmd_op,
    input  logic [SW-1:0]   cmd_dst,
    input  logic [SW-1:0]   cmd_src,
    input  logic [DW-1:0]   cmd_data,
    output logic            done,
    output logic [3*SW-1:0] rs_out,
    output logic            rw_out,
    output logic [DW-1:0]   d_out,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in
);

    rb_seq_state_t state_q, state_d;
    rb_seq_op_t    op_q, op_d;
    logic [SW-1:0] dst_q, dst_d, src_q, src_d, cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d, t0_q, t0_d, t1_q, t1_d;
    logic          done_q, done_d;
    logic          rw_moore;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            dst_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        rs_out    = '0;
        rw_moore  = 1'b0;
        d_out     = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    dst_d  = cmd_dst;
                    src_d  = cmd_src;
                    data_d = cmd_data;
                    cnt_d  = '0;
                    case (cmd_op)
                        OP_LOAD:          state_d = ST_WR1;
                        OP_MOVE, OP_SWAP: state_d = ST_RD;
                        OP_CLEAR:         state_d = ST_CLR;
                        default:          state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RD: begin
                rs_out = {{SW{1'b0}}, src_q, (op_q == OP_SWAP) ? dst_q : {SW{1'b0}}};
                t0_d   = a_in;
                if (op_q == OP_SWAP) t1_d = b_in;
                state_d = ST_WR1;
            end
            ST_WR1: begin
                rs_out   = {dst_q, {2*SW{1'b0}}};
                rw_moore = 1'b1;
                d_out    = (op_q == OP_LOAD) ? data_q : t0_q;
                if (op_q == OP_SWAP) begin
                    state_d = ST_WR2;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WR2: begin
                rs_out   = {src_q, {2*SW{1'b0}}};
                rw_moore = 1'b1;
                d_out    = t1_q;
                state_d  = ST_IDLE;
                done_d   = 1'b1;
            end
            ST_CLR: begin
                rs_out   = {cnt_q, {2*SW{1'b0}}};
                rw_moore = 1'b1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == {SW{1'b1}}) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with rst keeps a reset edge from committing a half-finished transfer.
    assign rw_out = rw_moore & ~rst;
    assign done   = done_q;

endmodule

// File: tb/tb_rb_seq.sv
// Scoreboard bench for rb_seq driving a behavioural 16x16 register bank.
module tb_rb_seq;
    import rb_seq_pkg::*;

    typedef struct {
        logic        rw;
        logic [11:0] rs;
        logic [15:0] d;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    rb_seq_op_t  cmd_op = OP_LOAD;
    logic [3:0]  cmd_dst = '0;
    logic [3:0]  cmd_src = '0;
    logic [15:0] cmd_data = '0;
    logic        done;
    logic [11:0] rs_out;
    logic        rw_out;
    logic [15:0] d_out;
    logic [15:0] a_in, b_in;

    logic [15:0] bank [16];
    logic [15:0] refr [16];
    exp_t        expq [$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        exp_done_next = 1'b0;

    rb_seq #(.DW(16), .SW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
        .done(done), .rs_out(rs_out), .rw_out(rw_out), .d_out(d_out),
        .a_in(a_in), .b_in(b_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rw_out) bank[rs_out[11:8]] <= d_out;
    assign a_in = bank[rs_out[7:4]];
    assign b_in = bank[rs_out[3:0]];

    function automatic exp_t mk(logic rw, logic [11:0] rs, logic [15:0] d, logic last);
        exp_t e;
        e.rw = rw; e.rs = rs; e.d = d; e.last = last;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every busy cycle must match the next expected port beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (done !== exp_done_next) begin
                    errors++;
                    $display("FAIL done_pulse actual=%b required=%b t=%0t", done, exp_done_next, $time);
                end
                if (cmd_ready !== 1'b1) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_busy actual rs=%h rw=%b required idle t=%0t", rs_out, rw_out, $time);
                        exp_done_next = 1'b0;
                    end else begin
                        e = expq.pop_front();
                        if (rw_out !== e.rw || rs_out !== e.rs || (e.rw && d_out !== e.d)) begin
                            errors++;
                            $display("FAIL busy_beat actual rw=%b rs=%h d=%h required rw=%b rs=%h d=%h t=%0t",
                                     rw_out, rs_out, d_out, e.rw, e.rs, e.d, $time);
                        end
                        exp_done_next = e.last;
                    end
                end else begin
                    checks++;
                    if (rs_out !== 12'h0 || rw_out !== 1'b0 || d_out !== 16'h0) begin
                        errors++;
                        $display("FAIL idle_outputs actual rs=%h rw=%b d=%h required zeros t=%0t",
                                 rs_out, rw_out, d_out, $time);
                    end
                    exp_done_next = 1'b0;
                end
            end
        end
    end

    task automatic issue(input rb_seq_op_t op, input logic [3:0] dst, input logic [3:0] src,
                         input logic [15:0] data);
        logic acc;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted op=%0d", op);
        end
    endtask

    task automatic expect_cmd(input rb_seq_op_t op, input logic [3:0] dst, input logic [3:0] src,
                              input logic [15:0] data);
        logic [15:0] v0, v1;
        case (op)
            OP_LOAD: begin
                expq.push_back(mk(1'b1, {dst, 8'h00}, data, 1'b1));
                refr[dst] = data;
            end
            OP_MOVE: begin
                expq.push_back(mk(1'b0, {4'h0, src, 4'h0}, 16'h0, 1'b0));
                expq.push_back(mk(1'b1, {dst, 8'h00}, refr[src], 1'b1));
                refr[dst] = refr[src];
            end
            OP_SWAP: begin
                v0 = refr[src];
                v1 = refr[dst];
                expq.push_back(mk(1'b0, {4'h0, src, dst}, 16'h0, 1'b0));
                expq.push_back(mk(1'b1, {dst, 8'h00}, v0, 1'b0));
                expq.push_back(mk(1'b1, {src, 8'h00}, v1, 1'b1));
                refr[dst] = v0;
                refr[src] = v1;
            end
            default: begin
                for (int i = 0; i < 16; i++) begin
                    expq.push_back(mk(1'b1, {4'(i), 8'h00}, 16'h0, i == 15));
                    refr[i] = 16'h0;
                end
            end
        endcase
    endtask

    task automatic cmd(input rb_seq_op_t op, input logic [3:0] dst, input logic [3:0] src,
                       input logic [15:0] data);
        issue(op, dst, src, data);
        expect_cmd(op, dst, src, data);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i] = 16'h0;
            refr[i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'h1);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_rs", 32'(rs_out), 32'h0);
        chk("reset_rw", 32'(rw_out), 32'h0);
        chk("reset_d", 32'(d_out), 32'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        cmd(OP_LOAD, 4'd3, 4'd0, 16'hA5A5);
        idle(3);
        chk("load_r3", 32'(bank[3]), 32'hA5A5);

        cmd(OP_LOAD, 4'd1, 4'd0, 16'h1234);
        cmd(OP_MOVE, 4'd9, 4'd1, 16'h0000);
        idle(4);
        chk("move_r9", 32'(bank[9]), 32'h1234);

        cmd(OP_LOAD, 4'd2, 4'd0, 16'h00FF);
        cmd(OP_LOAD, 4'd5, 4'd0, 16'hFF00);
        cmd(OP_SWAP, 4'd2, 4'd5, 16'h0000);
        idle(5);
        chk("swap_r2", 32'(bank[2]), 32'hFF00);
        chk("swap_r5", 32'(bank[5]), 32'h00FF);
        cmd(OP_SWAP, 4'd5, 4'd5, 16'h0000);
        idle(5);
        chk("swap_same_r5", 32'(bank[5]), 32'h00FF);

        for (int i = 0; i < 16; i++) cmd(OP_LOAD, 4'(i), 4'd0, 16'h8000 + 16'(i));
        idle(2);
        chk("preload_r15", 32'(bank[15]), 32'h800F);
        cmd(OP_CLEAR, 4'd7, 4'd3, 16'hFFFF);
        idle(20);
        for (int i = 0; i < 16; i++) chk($sformatf("clear_r%0d", i), 32'(bank[i]), 32'h0);

        cmd(OP_LOAD, 4'd7, 4'd0, 16'h7777);
        cmd(OP_LOAD, 4'd8, 4'd0, 16'h8888);
        issue(OP_SWAP, 4'd7, 4'd8, 16'h0000);
        cmd_valid = 1'b0;
        expq.push_back(mk(1'b0, 12'h087, 16'h0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        expq.push_back(mk(1'b0, 12'h700, 16'h0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(cmd_ready), 32'h1);
        chk("rst_mid_done", 32'(done), 32'h0);
        chk("rst_mid_rs", 32'(rs_out), 32'h0);
        idle(2);
        chk("rst_mid_r7", 32'(bank[7]), 32'h7777);
        chk("rst_mid_r8", 32'(bank[8]), 32'h8888);

        cmd(OP_CLEAR, 4'd0, 4'd0, 16'h0000);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_dst   = 4'd6;
        for (int k = 0; k < 15; k++) begin
            cmd_data = 16'h0100 + 16'(k);
            @(posedge clk);
            #1;
        end
        cmd(OP_LOAD, 4'd6, 4'd0, 16'hC0DE);
        idle(3);
        chk("hold_r6", 32'(bank[6]), 32'hC0DE);
        chk("hold_r0", 32'(bank[0]), 32'h0);
        chk("hold_r7", 32'(bank[7]), 32'h0);

        idle(5);
        chk("queue_drained", 32'(expq.size()), 32'h0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rb_seq.md
Name: rb_seq

Overview:
- Register-transfer sequencer that drives the write/read-select side of the CPU register bank.
- Bank port contract:
  - 12-bit select word: [11:8] write index, [7:4] read-A index, [3:0] read-B index.
  - Indices 0-7 select user registers; 8-15 select hidden registers.
  - Write enable and 16-bit write data are registered into the bank on the rising clock edge.
  - Both read ports are combinational.
- Accepts LOAD/MOVE/SWAP/CLEAR commands over a valid/ready handshake and runs each as a fixed multi-cycle sequence on that port.
- Used by the control unit for register initialisation and register-to-register moves.

Parameters:
- DW, 16, data width of bank registers
- SW, 4, register select field width (16 addressable registers)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  rb_seq_op_t: 0 LOAD, 1 MOVE, 2 SWAP, 3 CLEAR
- cmd_dst  in  SW  destination index
- cmd_src  in  SW  source index (MOVE/SWAP)
- cmd_data  in  DW  immediate (LOAD)
- done  out  1  one-cycle pulse: command fully committed
- rs_out  out  3*SW  to bank select word {wr, rdA, rdB}
- rw_out  out  1  to bank write enable
- d_out  out  DW  to bank write data
- a_in  in  DW  from bank read port A
- b_in  in  DW  from bank read port B

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset:
  - After any clk edge with rst=1: state IDLE, cmd_ready=1, done=0, rs_out=0, rw_out=0, d_out=0, temporaries t0/t1=0, counter=0.
  - rw_out = rw_q & ~rst (combinational gate), so no bank write commits on a reset edge, including mid-command.
  - The partially executed command is abandoned; no done is issued for it.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on an edge with cmd_valid & cmd_ready. Fields are latched at that edge.
  - In IDLE: rs_out=0, rw_out=0, d_out=0.
- States: IDLE, RD, WR1, WR2, CLR. Outputs are a Moore decode of state and internal registers.
- LOAD: IDLE -> WR1.
  - WR1: rs_out={dst,0,0}, rw_out=1, d_out=data.
  - -> IDLE. 1 busy cycle.
- MOVE: IDLE -> RD -> WR1.
  - RD: rs_out={0,src,0}, rw_out=0; a_in captured into t0 at the edge.
  - WR1: rs_out={dst,0,0}, rw_out=1, d_out=t0.
  - 2 busy cycles.
- SWAP: IDLE -> RD -> WR1 -> WR2.
  - RD: rs_out={0,src,dst}; t0<=a_in, t1<=b_in.
  - WR1: write dst<=t0.
  - WR2: rs_out={src,0,0}, d_out=t1, rw_out=1.
  - 3 busy cycles.
  - src==dst is legal; register contents are unchanged.
- CLEAR: IDLE -> CLR.
  - Counter runs 0..15; each cycle rs_out={cnt,0,0}, rw_out=1, d_out=0.
  - Counter wraps 15->0 and state -> IDLE. 16 busy cycles; writes all user and hidden registers.
  - cmd_dst, cmd_src and cmd_data are ignored.
- done:
  - Asserted in the IDLE cycle immediately following the last busy cycle, with cmd_ready=1.
  - A new command may be accepted in that same cycle (back-to-back, no bubble).
- Read-after-write: the bank commits on the edge ending the final write cycle, so a following command's RD sees the new value.
- No illegal ops (2-bit op fully decoded). An unreachable state returns to IDLE.

Decomposition:
- mycpu_pkg additions:
  - rb_seq_op_t enum (LOAD/MOVE/SWAP/CLEAR)
  - rb_seq_state_t enum
  - constants RB_SEL_W=4, RB_NREGS=16, RB_HIDDEN_BASE=4'h8
- Single module, no sub-module; CLR counter and FSM are small enough inline.
- Bench instantiates rb_seq with the existing register bank for end-to-end checks.

Test Plan:
- Reset then LOAD dst=3 data=16'hA5A5 -> exactly one cycle with rs_out=12'h300, rw_out=1, d_out=16'hA5A5; done next cycle; bank reg3=16'hA5A5.
- LOAD r1=16'h1234, then MOVE dst=9 src=1 back-to-back -> RD rs_out=12'h010; WR rs_out=12'h900, d_out=16'h1234; hidden reg 1 (index 9)=16'h1234; cmd_ready low for exactly 2 cycles.
- LOAD r2=16'h00FF, r5=16'hFF00, SWAP dst=2 src=5 -> r2=16'hFF00, r5=16'h00FF after 3 busy cycles. SWAP dst=src=5 -> r5 unchanged.
- Preload all 16 registers non-zero, CLEAR -> 16 consecutive rw_out=1 cycles with write index 0..15, all registers 0, single done pulse, counter back at 0.
- Assert rst during SWAP WR1 cycle -> no bank write at that edge (src and dst retain old values); after reset cmd_ready=1, done=0, rs_out=0.
- Hold cmd_valid high with changing cmd_data while busy -> fields changes ignored until cmd_ready=1; only the value present at the accepting edge is written.
